vending_ctrl_multi: RTL and testbench

Parametrised successor to the single-product refreshment-machine controller. It accumulates credit from two coin denominations and vends one of N_PROD products at a common price. It returns change one unit at a time, refunds on cancel, and reports refused coins and selections. It sits between the coin/button front-end and the dispenser/change-hopper drivers.

---
 rtl/vending_ctrl_multi_if.sv | 28 ++
 rtl/vending_ctrl_multi.sv | 149 ++++++++++++++
 tb/tb_vending_ctrl_multi.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vending_ctrl_multi_if.sv
// Coin/button front-end and dispenser/hopper signal bundle for vending_ctrl_multi.
// The controller uses the slave modport and the front-end uses the master modport.
interface vending_ctrl_multi_if #(
  parameter int N_PROD   = 2,
  parameter int CREDIT_W = 3
);
  logic                M;
  logic                N;
  logic                C;
  logic [N_PROD-1:0]   SEL;
  logic [N_PROD-1:0]   STOCK_EMPTY;
  logic [N_PROD-1:0]   VEND;
  logic                CHANGE;
  logic                REJECT;
  logic                DENY;
  logic [CREDIT_W-1:0] CREDIT;
  logic                BUSY;

  modport master (
    output M, N, C, SEL, STOCK_EMPTY,
    input  VEND, CHANGE, REJECT, DENY, CREDIT, BUSY
  );

  modport slave (
    input  M, N, C, SEL, STOCK_EMPTY,
    output VEND, CHANGE, REJECT, DENY, CREDIT, BUSY
  );
endinterface

// File: rtl/vending_ctrl_multi.sv
// Multi-product vending controller: two coin values, common price, unit change and refund.
// Optional VEND_INACTIVITY_TIMEOUT_EN adds an idle timer that refunds held credit.
module vending_ctrl_multi #(
  parameter int N_PROD     = 2,
  parameter int CREDIT_W   = 3,
  parameter int MAX_CREDIT = 7,
  parameter int PRICE      = 3,
  parameter int VAL_M      = 1,
  parameter int VAL_N      = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic                  CLK,
  input  logic                  RST,
  vending_ctrl_multi_if.slave   bus
);

  localparam int IDX_W = (N_PROD > 1) ? $clog2(N_PROD) : 1;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_VEND    = 2'd1,
    S_CHANGE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [N_PROD-1:0]   vend_q, vend_d;
  logic                change_q, change_d;
  logic                reject_q, reject_d;
  logic                deny_q, deny_d;
  logic                busy_q, busy_d;
  logic [IDX_W-1:0]    sel_idx;
  logic                any_input;

`ifdef VEND_INACTIVITY_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT + 1);
  logic [TIMER_W-1:0]  timer_q, timer_d;
`endif

  // Outputs are computed one edge ahead, so VEND/CHANGE line up with the state they belong to.
  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    vend_d    = '0;
    change_d  = 1'b0;
    reject_d  = 1'b0;
    deny_d    = 1'b0;
    sel_idx   = '0;
    any_input = bus.M | bus.N | bus.C | (|bus.SEL);
`ifdef VEND_INACTIVITY_TIMEOUT_EN
    timer_d   = '0;
`endif

    for (int i = N_PROD - 1; i >= 0; i--) begin
      if (bus.SEL[i]) sel_idx = IDX_W'(i);
    end

    case (state_q)
      S_COLLECT: begin
        if (bus.M) begin
          if (int'(credit_q) + VAL_M > MAX_CREDIT) reject_d = 1'b1;
          else credit_d = credit_q + CREDIT_W'(VAL_M);
          if (bus.N) reject_d = 1'b1;
        end else if (bus.N) begin
          if (int'(credit_q) + VAL_N > MAX_CREDIT) reject_d = 1'b1;
          else credit_d = credit_q + CREDIT_W'(VAL_N);
        end else if (|bus.SEL) begin
          if (int'(credit_q) >= PRICE && !bus.STOCK_EMPTY[sel_idx]) begin
            state_d         = S_VEND;
            vend_d[sel_idx] = 1'b1;
            credit_d        = credit_q - CREDIT_W'(PRICE);
          end else begin
            deny_d = 1'b1;
          end
        end else if (bus.C) begin
          if (credit_q != '0) begin
            state_d  = S_CHANGE;
            change_d = 1'b1;
            credit_d = credit_q - 1'b1;
          end
        end
`ifdef VEND_INACTIVITY_TIMEOUT_EN
        // Idle credit counts toward an automatic refund; any front-end activity restarts it.
        else if (credit_q != '0) begin
          if (int'(timer_q) + 1 >= TIMEOUT) begin
            state_d  = S_CHANGE;
            change_d = 1'b1;
            credit_d = credit_q - 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
`endif
      end

      S_VEND, S_CHANGE: begin
        reject_d = bus.M | bus.N;
        if (credit_q != '0) begin
          state_d  = S_CHANGE;
          change_d = 1'b1;
          credit_d = credit_q - 1'b1;
        end else begin
          state_d = S_COLLECT;
        end
      end

      default: begin
        state_d  = S_COLLECT;
        credit_d = '0;
      end
    endcase

    busy_d = (state_d != S_COLLECT);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_COLLECT;
      credit_q <= '0;
      vend_q   <= '0;
      change_q <= 1'b0;
      reject_q <= 1'b0;
      deny_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef VEND_INACTIVITY_TIMEOUT_EN
      timer_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      vend_q   <= vend_d;
      change_q <= change_d;
      reject_q <= reject_d;
      deny_q   <= deny_d;
      busy_q   <= busy_d;
`ifdef VEND_INACTIVITY_TIMEOUT_EN
      timer_q  <= timer_d;
`endif
    end
  end

  assign bus.VEND   = vend_q;
  assign bus.CHANGE = change_q;
  assign bus.REJECT = reject_q;
  assign bus.DENY   = deny_q;
  assign bus.CREDIT = credit_q;
  assign bus.BUSY   = busy_q;

endmodule

// File: tb/tb_vending_ctrl_multi.sv
// Self-checking bench for vending_ctrl_multi: schedule-based reference model plus directed checks.
// Honours VEND_INACTIVITY_TIMEOUT_EN the same way as the design.
module tb_vending_ctrl_multi;

  localparam int N_PROD     = 2;
  localparam int CREDIT_W   = 3;
  localparam int MAX_CREDIT = 7;
  localparam int PRICE      = 3;
  localparam int VAL_M      = 1;
  localparam int VAL_N      = 2;
  localparam int TIMEOUT    = 15;

  logic CLK;
  logic RST;
  int   tests;
  int   fails;

  vending_ctrl_multi_if #(.N_PROD(N_PROD), .CREDIT_W(CREDIT_W)) bus ();

  vending_ctrl_multi #(
    .N_PROD(N_PROD), .CREDIT_W(CREDIT_W), .MAX_CREDIT(MAX_CREDIT), .PRICE(PRICE),
    .VAL_M(VAL_M), .VAL_N(VAL_N), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: a transaction becomes a list of future output cycles.
  typedef struct {
    logic [N_PROD-1:0] vend;
    logic              change;
    int                credit;
  } step_t;

  step_t             sched[$];
  step_t             step;
  int                m_credit;
  int                idle_cnt;
  int                sel_lo;
  logic              model_valid;
  logic [N_PROD-1:0] exp_vend;
  logic              exp_change;
  logic              exp_reject;
  logic              exp_deny;
  logic              exp_busy;

  task automatic scheduleRefund(input int from_credit);
    step_t s;
    for (int k = from_credit - 1; k >= 0; k--) begin
      s.vend = '0; s.change = 1'b1; s.credit = k;
      sched.push_back(s);
    end
  endtask

  task automatic scheduleSale(input int idx);
    step_t s;
    s.vend = '0; s.vend[idx] = 1'b1; s.change = 1'b0; s.credit = m_credit - PRICE;
    sched.push_back(s);
    scheduleRefund(m_credit - PRICE);
  endtask

  task automatic startSchedule();
    step = sched.pop_front();
    exp_vend = step.vend; exp_change = step.change; m_credit = step.credit; exp_busy = 1'b1;
    idle_cnt = 0;
  endtask

  always @(posedge CLK) begin
    if (RST) begin
      sched.delete();
      m_credit = 0; idle_cnt = 0;
      exp_vend = '0; exp_change = 1'b0; exp_reject = 1'b0; exp_deny = 1'b0; exp_busy = 1'b0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      exp_vend = '0; exp_change = 1'b0; exp_reject = 1'b0; exp_deny = 1'b0;
      if (exp_busy) begin
        exp_reject = bus.M | bus.N;
        idle_cnt = 0;
        if (sched.size() > 0) startSchedule();
        else exp_busy = 1'b0;
      end else if (bus.M) begin
        idle_cnt = 0;
        if (m_credit + VAL_M <= MAX_CREDIT) m_credit += VAL_M;
        else exp_reject = 1'b1;
        if (bus.N) exp_reject = 1'b1;
      end else if (bus.N) begin
        idle_cnt = 0;
        if (m_credit + VAL_N <= MAX_CREDIT) m_credit += VAL_N;
        else exp_reject = 1'b1;
      end else if (bus.SEL != '0) begin
        idle_cnt = 0;
        sel_lo = -1;
        for (int i = 0; i < N_PROD; i++) if (bus.SEL[i] && sel_lo < 0) sel_lo = i;
        if (m_credit >= PRICE && !bus.STOCK_EMPTY[sel_lo]) begin
          scheduleSale(sel_lo);
          startSchedule();
        end else begin
          exp_deny = 1'b1;
        end
      end else if (bus.C) begin
        idle_cnt = 0;
        if (m_credit > 0) begin
          scheduleRefund(m_credit);
          startSchedule();
        end
      end else if (m_credit > 0) begin
        idle_cnt++;
`ifdef VEND_INACTIVITY_TIMEOUT_EN
        if (idle_cnt >= TIMEOUT) begin
          scheduleRefund(m_credit);
          startSchedule();
        end
`endif
      end else begin
        idle_cnt = 0;
      end
    end
  end

  // Every cycle after the first reset edge, the DUT must match the model.
  always @(negedge CLK) begin
    if (model_valid === 1'b1) begin
      tests++;
      if (bus.VEND !== exp_vend || bus.CHANGE !== exp_change || bus.REJECT !== exp_reject ||
          bus.DENY !== exp_deny || bus.BUSY !== exp_busy || int'(bus.CREDIT) != m_credit) begin
        fails++;
        $display("[TB] FAIL model t=%0t got vend=%b change=%b reject=%b deny=%b busy=%b credit=%0d expected vend=%b change=%b reject=%b deny=%b busy=%b credit=%0d",
                 $time, bus.VEND, bus.CHANGE, bus.REJECT, bus.DENY, bus.BUSY, bus.CREDIT,
                 exp_vend, exp_change, exp_reject, exp_deny, exp_busy, m_credit);
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic m, input logic n, input logic c, input logic [N_PROD-1:0] sel);
    bus.M = m; bus.N = n; bus.C = c; bus.SEL = sel;
    @(negedge CLK);
    bus.M = 1'b0; bus.N = 1'b0; bus.C = 1'b0; bus.SEL = '0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge CLK);
  endtask

  task automatic pulseReset();
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tests = 0; fails = 0; model_valid = 1'b0;
    RST = 1'b1;
    bus.M = 1'b0; bus.N = 1'b0; bus.C = 1'b0; bus.SEL = '0; bus.STOCK_EMPTY = '0;
    idle(2);
    RST = 1'b0;
    checkOutput("reset_credit", int'(bus.CREDIT), 0);
    checkOutput("reset_busy", int'(bus.BUSY), 0);

    // Basic sale with change
    applyStimulus(1, 0, 0, 2'b00);
    checkOutput("t1_credit_m", int'(bus.CREDIT), 1);
    applyStimulus(0, 1, 0, 2'b00);
    applyStimulus(0, 1, 0, 2'b00);
    checkOutput("t1_credit_5", int'(bus.CREDIT), 5);
    applyStimulus(0, 0, 0, 2'b01);
    checkOutput("t1_vend", int'(bus.VEND), 1);
    checkOutput("t1_vend_credit", int'(bus.CREDIT), 2);
    idle(1);
    checkOutput("t1_change1", int'(bus.CHANGE), 1);
    idle(1);
    checkOutput("t1_change2", int'(bus.CHANGE), 1);
    checkOutput("t1_change2_credit", int'(bus.CREDIT), 0);
    idle(1);
    checkOutput("t1_done_busy", int'(bus.BUSY), 0);

    // Ceiling and simultaneous coins
    applyStimulus(0, 1, 0, 2'b00);
    applyStimulus(0, 1, 0, 2'b00);
    applyStimulus(0, 1, 0, 2'b00);
    applyStimulus(0, 1, 0, 2'b00);
    checkOutput("t2_overflow_reject", int'(bus.REJECT), 1);
    checkOutput("t2_overflow_credit", int'(bus.CREDIT), 6);
    applyStimulus(0, 0, 1, 2'b00);
    idle(7);
    applyStimulus(1, 1, 0, 2'b00);
    checkOutput("t2_both_credit", int'(bus.CREDIT), 1);
    checkOutput("t2_both_reject", int'(bus.REJECT), 1);
    applyStimulus(0, 0, 1, 2'b00);
    idle(2);

    // Denied selections and lowest-bit priority
    applyStimulus(0, 1, 0, 2'b00);
    applyStimulus(0, 0, 0, 2'b10);
    checkOutput("t3_deny_credit", int'(bus.DENY), 1);
    checkOutput("t3_deny_credit_kept", int'(bus.CREDIT), 2);
    applyStimulus(1, 0, 0, 2'b00);
    bus.STOCK_EMPTY = 2'b10;
    applyStimulus(0, 0, 0, 2'b10);
    checkOutput("t3_deny_stock", int'(bus.DENY), 1);
    applyStimulus(0, 0, 0, 2'b11);
    checkOutput("t3_vend_low", int'(bus.VEND), 1);
    idle(1);
    checkOutput("t3_done_busy", int'(bus.BUSY), 0);
    bus.STOCK_EMPTY = 2'b00;

    // Cancel refund with a coin arriving mid-refund
    applyStimulus(0, 1, 0, 2'b00);
    applyStimulus(0, 1, 0, 2'b00);
    applyStimulus(0, 0, 1, 2'b00);
    checkOutput("t4_change_start", int'(bus.CHANGE), 1);
    applyStimulus(1, 0, 0, 2'b00);
    checkOutput("t4_busy_reject", int'(bus.REJECT), 1);
    checkOutput("t4_busy_credit", int'(bus.CREDIT), 2);
    idle(2);
    checkOutput("t4_last_change", int'(bus.CHANGE), 1);
    idle(1);
    applyStimulus(0, 0, 1, 2'b00);
    checkOutput("t4_cancel_zero_busy", int'(bus.BUSY), 0);
    checkOutput("t4_cancel_zero_change", int'(bus.CHANGE), 0);

    // Reset in the middle of a refund discards the rest
    applyStimulus(0, 1, 0, 2'b00);
    applyStimulus(0, 1, 0, 2'b00);
    applyStimulus(0, 0, 1, 2'b00);
    idle(1);
    checkOutput("t5_second_change", int'(bus.CHANGE), 1);
    pulseReset();
    checkOutput("t5_rst_credit", int'(bus.CREDIT), 0);
    checkOutput("t5_rst_change", int'(bus.CHANGE), 0);
    checkOutput("t5_rst_busy", int'(bus.BUSY), 0);

    // Inactivity behaviour
`ifdef VEND_INACTIVITY_TIMEOUT_EN
    applyStimulus(0, 1, 0, 2'b00);
    idle(14);
    checkOutput("t6_hold_credit", int'(bus.CREDIT), 2);
    idle(1);
    checkOutput("t6_timeout_change", int'(bus.CHANGE), 1);
    idle(3);
    applyStimulus(0, 1, 0, 2'b00);
    idle(9);
    applyStimulus(1, 0, 0, 2'b00);
    idle(14);
    checkOutput("t6_restart_hold", int'(bus.BUSY), 0);
    checkOutput("t6_restart_credit", int'(bus.CREDIT), 3);
    idle(1);
    checkOutput("t6_restart_change", int'(bus.CHANGE), 1);
    idle(4);
`else
    applyStimulus(0, 1, 0, 2'b00);
    idle(100);
    checkOutput("t6_hold_credit", int'(bus.CREDIT), 2);
    checkOutput("t6_hold_busy", int'(bus.BUSY), 0);
    applyStimulus(0, 0, 1, 2'b00);
    idle(3);
`endif

    // Mixed traffic soak, checked by the model every cycle
    for (int k = 0; k < 300; k++) begin
      bus.STOCK_EMPTY = ($urandom_range(0, 3) == 0) ? N_PROD'($urandom_range(0, 3)) : '0;
      applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 4) == 0) ? N_PROD'($urandom_range(1, 3)) : '0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 6));
    end
    idle(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
